// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM word, RAM handshake state, arbiter state, grant id.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } arb_state_t;

    // grant_id = {class, core}; class 1 = dcache, 0 = icache
    localparam int unsigned ARB_CPUS   = 2;
    localparam int unsigned GRANT_ID_W = $clog2(2 * ARB_CPUS);
    typedef logic [GRANT_ID_W-1:0] grant_id_t;

    localparam logic CLASS_I = 1'b0;
    localparam logic CLASS_D = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// N-way round-robin picker: first active request at or after the pointer wins.
// Ports: i_req request vector, i_ptr start index, o_gnt one-hot grant, o_valid any grant.
module rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_valid
);

    logic [PW-1:0] w_idx;

    // Scan from the pointer with wrap-around; the first hit is latched by o_valid
    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = PW'((32'(i_ptr) + off) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port among per-core icache and dcache miss ports.
// dcaches outrank icaches, round-robin within a class, starved icaches outrank all;
// a dcache holds the port for a whole block. One IDLE cycle separates grants.
// Ports: CLK/nRST; iREN/iaddr/iwait/iload icache side; dREN/dWEN/daddr/dstore/dwait/dload
// dcache side; ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate RAM side; grant_id owner.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned CPUS         = 2,
    parameter int unsigned BLOCK_WORDS  = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic [CPUS-1:0]               iREN,
    input  word_t                         iaddr [CPUS],
    output logic [CPUS-1:0]               iwait,
    output word_t                         iload,
    input  logic [CPUS-1:0]               dREN,
    input  logic [CPUS-1:0]               dWEN,
    input  word_t                         daddr [CPUS],
    input  word_t                         dstore [CPUS],
    output logic [CPUS-1:0]               dwait,
    output word_t                         dload,
    output logic                          ramREN,
    output logic                          ramWEN,
    output word_t                         ramaddr,
    output word_t                         ramstore,
    input  word_t                         ramload,
    input  ramstate_t                     ramstate,
    output logic [$clog2(2*CPUS)-1:0]     grant_id
);

    localparam int unsigned CW = $clog2(CPUS);
    localparam int unsigned GW = $clog2(2 * CPUS);
    localparam int unsigned BW = $clog2(BLOCK_WORDS + 1);
    localparam int unsigned SW = 4;

    arb_state_t     r_state;
    logic [CW-1:0]  r_owner;
    logic [CW-1:0]  r_dptr;
    logic [CW-1:0]  r_iptr;
    logic [BW-1:0]  r_beat;
    logic [SW-1:0]  r_starve [CPUS];
    logic [GW-1:0]  r_grant_id;

    logic [CPUS-1:0] w_dreq;
    logic [CPUS-1:0] w_d_gnt;
    logic [CPUS-1:0] w_i_gnt;
    logic            w_d_valid;
    logic            w_i_valid;
    logic [CPUS-1:0] w_starved;
    logic            w_s_valid;
    logic [CW-1:0]   w_s_idx;
    logic [CW-1:0]   w_d_idx;
    logic [CW-1:0]   w_i_idx;
    logic            w_own_req;
    logic            w_done;

    function automatic logic [CW-1:0] next_core(input logic [CW-1:0] c);
        return (c == CW'(CPUS - 1)) ? '0 : c + CW'(1);
    endfunction

    assign w_dreq = dREN | dWEN;

    rr_pick #(.N(CPUS)) u_d_pick (
        .i_req   (w_dreq),
        .i_ptr   (r_dptr),
        .o_gnt   (w_d_gnt),
        .o_valid (w_d_valid)
    );

    rr_pick #(.N(CPUS)) u_i_pick (
        .i_req   (iREN),
        .i_ptr   (r_iptr),
        .o_gnt   (w_i_gnt),
        .o_valid (w_i_valid)
    );

    // Starved-icache detect (lowest index wins) and one-hot to index
    always_comb begin
        w_s_valid = 1'b0;
        w_s_idx   = '0;
        w_d_idx   = '0;
        w_i_idx   = '0;
        w_starved = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            w_starved[k] = iREN[k] && (r_starve[k] >= SW'(STARVE_LIMIT));
            if (w_starved[k] && !w_s_valid) begin
                w_s_valid = 1'b1;
                w_s_idx   = CW'(k);
            end
            if (w_d_gnt[k]) w_d_idx = CW'(k);
            if (w_i_gnt[k]) w_i_idx = CW'(k);
        end
    end

    // A beat completes only while the owner still requests
    always_comb begin
        w_own_req = 1'b0;
        case (r_state)
            GRANT_D: w_own_req = w_dreq[r_owner];
            GRANT_I: w_own_req = iREN[r_owner];
            default: w_own_req = 1'b0;
        endcase
    end

    assign w_done = w_own_req && (ramstate == ACCESS);

    // RAM strobes follow the owner's live inputs; write wins over read
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        case (r_state)
            GRANT_D: begin
                ramaddr  = daddr[r_owner];
                ramstore = dstore[r_owner];
                ramWEN   = dWEN[r_owner];
                ramREN   = dREN[r_owner] & ~dWEN[r_owner];
                if (w_done) dwait[r_owner] = 1'b0;
            end
            GRANT_I: begin
                ramaddr = iaddr[r_owner];
                ramREN  = iREN[r_owner];
                if (w_done) iwait[r_owner] = 1'b0;
            end
            default: ;
        endcase
    end

    assign iload    = ramload;
    assign dload    = ramload;
    assign grant_id = r_grant_id;

    // Arbitration FSM
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_dptr     <= '0;
            r_iptr     <= '0;
            r_beat     <= '0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_s_valid) begin
                        r_state    <= GRANT_I;
                        r_owner    <= w_s_idx;
                        r_iptr     <= next_core(w_s_idx);
                        r_grant_id <= {CLASS_I, w_s_idx};
                    end else if (w_d_valid) begin
                        r_state    <= GRANT_D;
                        r_owner    <= w_d_idx;
                        r_dptr     <= next_core(w_d_idx);
                        r_grant_id <= {CLASS_D, w_d_idx};
                    end else if (w_i_valid) begin
                        r_state    <= GRANT_I;
                        r_owner    <= w_i_idx;
                        r_iptr     <= next_core(w_i_idx);
                        r_grant_id <= {CLASS_I, w_i_idx};
                    end
                end
                GRANT_D: begin
                    if (!w_own_req) begin
                        r_state <= IDLE;
                        r_beat  <= '0;
                    end else if (w_done) begin
                        if (r_beat == BW'(BLOCK_WORDS - 1)) begin
                            r_state <= IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
                GRANT_I: begin
                    if (!w_own_req || w_done) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Per-icache saturating wait counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned k = 0; k < CPUS; k++) r_starve[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < CPUS; k++) begin
                if (!iREN[k] || (r_state == GRANT_I && r_owner == CW'(k) && w_done))
                    r_starve[k] <= '0;
                else if (r_starve[k] != '1)
                    r_starve[k] <= r_starve[k] + SW'(1);
            end
        end
    end

endmodule
